// File: rtl/rtc_time_counter.sv
// Calendar time counter: 1 Hz prescaler, binary ss/mm/hh/dd/mo/yyyy with Gregorian leap years,
// and an edit mode that steps one field at a time without carries.
module rtc_time_counter #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        edit_mode,
  input  logic [2:0]  field_sel,
  input  logic        inc_pulse,
  input  logic        dec_pulse,
  output logic [5:0]  binary_seconds,
  output logic [5:0]  binary_minutes,
  output logic [4:0]  binary_hours,
  output logic [4:0]  binary_day,
  output logic [3:0]  binary_month,
  output logic [11:0] binary_year,
  output logic        sec_tick
);

  localparam int          PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [11:0] YMIN_V   = 12'(YEAR_MIN);
  localparam logic [11:0] YMAX_V   = 12'(YEAR_MAX);

  typedef enum logic [2:0] {
    F_SS = 3'd0,
    F_MM = 3'd1,
    F_HH = 3'd2,
    F_DD = 3'd3,
    F_MO = 3'd4,
    F_YY = 3'd5
  } field_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          stick_q, stick_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [4:0]    day_q, day_d;
  logic [3:0]    mon_q, mon_d;
  logic [11:0]   year_q, year_d;
  logic [4:0]    dim_cur;
  logic [4:0]    dim_new;

  function automatic logic is_leap(input logic [11:0] y);
    return ((y % 12'd4) == 12'd0) &&
           (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
  endfunction

  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [11:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    stick_d = 1'b0;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    mon_d   = mon_q;
    year_d  = year_q;
    dim_cur = dim_f(mon_q, year_q);
    dim_new = 5'd31;

    if (edit_mode) begin
      // Holding the prescaler at 0 and dropping a pending tick gives a full first second on exit.
      presc_d = '0;
      tick_d  = 1'b0;
      if (en && (inc_pulse ^ dec_pulse)) begin
        case (field_sel)
          F_SS: begin
            if (inc_pulse) sec_d = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
            else           sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
          end
          F_MM: begin
            if (inc_pulse) min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
            else           min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
          end
          F_HH: begin
            if (inc_pulse) hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
            else           hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
          end
          F_DD: begin
            if (inc_pulse) day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
            else           day_d = (day_q <= 5'd1) ? dim_cur : day_q - 5'd1;
          end
          F_MO: begin
            if (inc_pulse) mon_d = (mon_q >= 4'd12) ? 4'd1 : mon_q + 4'd1;
            else           mon_d = (mon_q <= 4'd1) ? 4'd12 : mon_q - 4'd1;
          end
          F_YY: begin
            if (inc_pulse) year_d = (year_q >= YMAX_V) ? YMIN_V : year_q + 12'd1;
            else           year_d = (year_q <= YMIN_V) ? YMAX_V : year_q - 12'd1;
          end
          default: ;
        endcase
        dim_new = dim_f(mon_d, year_d);
        if (day_d > dim_new) day_d = dim_new;
      end
    end else if (en) begin
      if (presc_q == PRESC_TC) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
        tick_d  = 1'b0;
      end

      if (tick_q) begin
        stick_d = 1'b1;
        if (sec_q >= 6'd59) begin
          sec_d = 6'd0;
          if (min_q >= 6'd59) begin
            min_d = 6'd0;
            if (hour_q >= 5'd23) begin
              hour_d = 5'd0;
              if (day_q >= dim_cur) begin
                day_d = 5'd1;
                if (mon_q >= 4'd12) begin
                  mon_d  = 4'd1;
                  year_d = (year_q >= YMAX_V) ? YMIN_V : year_q + 12'd1;
                end else begin
                  mon_d = mon_q + 4'd1;
                end
              end else begin
                day_d = day_q + 5'd1;
              end
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      stick_q <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= 5'd1;
      mon_q   <= 4'd1;
      year_q  <= YMIN_V;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      stick_q <= stick_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      mon_q   <= mon_d;
      year_q  <= year_d;
    end
  end

  assign binary_seconds = sec_q;
  assign binary_minutes = min_q;
  assign binary_hours   = hour_q;
  assign binary_day     = day_q;
  assign binary_month   = mon_q;
  assign binary_year    = year_q;
  assign sec_tick       = stick_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: edit-mode vector table, calendar corner sequences and a
// randomized run, all checked against a calendar-level reference model.
module tb_rtc_time_counter;

  localparam int CLK_HZ = 4;
  localparam int YMIN   = 2000;
  localparam int YMAX   = 2999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        edit_mode = 1'b0;
  logic [2:0]  field_sel = '0;
  logic        inc_pulse = 1'b0;
  logic        dec_pulse = 1'b0;
  logic [5:0]  binary_seconds;
  logic [5:0]  binary_minutes;
  logic [4:0]  binary_hours;
  logic [4:0]  binary_day;
  logic [3:0]  binary_month;
  logic [11:0] binary_year;
  logic        sec_tick;

  rtc_time_counter #(.CLK_HZ(CLK_HZ), .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .edit_mode(edit_mode), .field_sel(field_sel),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .binary_seconds(binary_seconds), .binary_minutes(binary_minutes),
    .binary_hours(binary_hours), .binary_day(binary_day), .binary_month(binary_month),
    .binary_year(binary_year), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference calendar state; run counts running cycles since the prescaler last restarted.
  int ms, mm, mh, md, mmo, my, run;
  bit pend, mtick;

  typedef struct {
    bit en; bit edit; int sel; bit inc; bit dec;
    int s; int m; int h; int d; int mo; int y;
  } vec_t;
  vec_t tbl[20];

  function automatic int m_dim(int mo, int y);
    int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int d = tab[mo - 1];
    if (mo == 2 && (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0))) d = 29;
    return d;
  endfunction

  task automatic m_reset();
    ms = 0; mm = 0; mh = 0; md = 1; mmo = 1; my = YMIN; run = 0; pend = 0; mtick = 0;
  endtask

  task automatic m_advance();
    ms++;
    if (ms == 60) begin
      ms = 0; mm++;
      if (mm == 60) begin
        mm = 0; mh++;
        if (mh == 24) begin
          mh = 0; md++;
          if (md > m_dim(mmo, my)) begin
            md = 1; mmo++;
            if (mmo > 12) begin
              mmo = 1; my++;
              if (my > YMAX) my = YMIN;
            end
          end
        end
      end
    end
  endtask

  task automatic m_edit(int sel, bit up);
    int st = up ? 1 : -1;
    case (sel)
      0: ms = (ms + 60 + st) % 60;
      1: mm = (mm + 60 + st) % 60;
      2: mh = (mh + 24 + st) % 24;
      3: begin
        md = md + st;
        if (md > m_dim(mmo, my)) md = 1;
        if (md < 1) md = m_dim(mmo, my);
      end
      4: begin
        mmo = mmo + st;
        if (mmo > 12) mmo = 1;
        if (mmo < 1) mmo = 12;
      end
      5: begin
        my = my + st;
        if (my > YMAX) my = YMIN;
        if (my < YMIN) my = YMAX;
      end
      default: ;
    endcase
    if (md > m_dim(mmo, my)) md = m_dim(mmo, my);
  endtask

  task automatic m_step(bit e, bit ed, int sel, bit inc, bit dec);
    mtick = 0;
    if (ed) begin
      run = 0; pend = 0;
      if (e && (inc != dec)) m_edit(sel, inc);
    end else if (e) begin
      if (pend) begin m_advance(); mtick = 1; end
      run++;
      pend = (run == CLK_HZ);
      if (pend) run = 0;
    end
  endtask

  function automatic int m_val(int sel);
    case (sel)
      0: return ms;
      1: return mm;
      2: return mh;
      3: return md;
      4: return mmo;
      default: return my;
    endcase
  endfunction

  function automatic logic [38:0] pk(int s, int m, int h, int d, int mo, int y, int t);
    return {6'(s), 6'(m), 5'(h), 5'(d), 4'(mo), 12'(y), 1'(t)};
  endfunction

  function automatic logic [38:0] dut_pk();
    return {binary_seconds, binary_minutes, binary_hours, binary_day, binary_month,
            binary_year, sec_tick};
  endfunction

  function automatic string fmt(logic [38:0] v);
    return $sformatf("%0d:%0d:%0d %0d/%0d/%0d tick=%0d", v[38:33], v[32:27], v[26:22],
                     v[21:17], v[16:13], v[12:1], v[0]);
  endfunction

  task automatic chk(string nm, logic [38:0] got, logic [38:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", nm, fmt(got), fmt(exp));
    end
  endtask

  task automatic chk_i(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic go(bit e, bit ed, int sel, bit inc, bit dec);
    en = e; edit_mode = ed; field_sel = 3'(sel); inc_pulse = inc; dec_pulse = dec;
    @(posedge clk);
    m_step(e, ed, sel, inc, dec);
    #1;
    chk("model", dut_pk(), pk(ms, mm, mh, md, mmo, my, mtick));
  endtask

  task automatic set_field(int sel, int target);
    for (int g = 0; g < 1100 && m_val(sel) != target; g++) go(1, 1, sel, 1, 0);
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    for (int i = 1; i <= 3 * CLK_HZ + 4; i++) begin
      go(1, 0, 0, 0, 0);
      if (sec_tick === 1'b1) begin n = i; break; end
    end
    if (n == 0) begin
      checks++; errors++;
      $display("FAIL tick_timeout: got no sec_tick expected one within %0d cycles", 3 * CLK_HZ + 4);
    end
  endtask

  task automatic leap_case(string nm, int y, int mo, int d, int ed, int emo);
    int n;
    set_field(5, y); set_field(4, mo); set_field(3, d);
    set_field(2, 23); set_field(1, 59); set_field(0, 59);
    run_to_tick(n);
    chk(nm, dut_pk(), pk(0, 0, 0, ed, emo, y, 1));
  endtask

  initial begin
    int t1, t2, n, saved;
    bit ed;

    tbl[0]  = '{1, 1, 0, 1, 0,  1,  0,  0,  1,  1, 2000};
    tbl[1]  = '{1, 1, 0, 0, 1,  0,  0,  0,  1,  1, 2000};
    tbl[2]  = '{1, 1, 0, 0, 1, 59,  0,  0,  1,  1, 2000};
    tbl[3]  = '{1, 1, 0, 1, 0,  0,  0,  0,  1,  1, 2000};
    tbl[4]  = '{1, 1, 0, 1, 1,  0,  0,  0,  1,  1, 2000};
    tbl[5]  = '{1, 1, 7, 1, 0,  0,  0,  0,  1,  1, 2000};
    tbl[6]  = '{1, 1, 6, 0, 1,  0,  0,  0,  1,  1, 2000};
    tbl[7]  = '{1, 1, 1, 0, 1,  0, 59,  0,  1,  1, 2000};
    tbl[8]  = '{1, 1, 2, 0, 1,  0, 59, 23,  1,  1, 2000};
    tbl[9]  = '{1, 1, 3, 0, 1,  0, 59, 23, 31,  1, 2000};
    tbl[10] = '{1, 1, 4, 0, 1,  0, 59, 23, 31, 12, 2000};
    tbl[11] = '{1, 1, 5, 0, 1,  0, 59, 23, 31, 12, 2999};
    tbl[12] = '{0, 1, 5, 1, 0,  0, 59, 23, 31, 12, 2999};
    tbl[13] = '{1, 1, 5, 1, 0,  0, 59, 23, 31, 12, 2000};
    tbl[14] = '{1, 1, 4, 1, 0,  0, 59, 23, 31,  1, 2000};
    tbl[15] = '{1, 1, 4, 1, 0,  0, 59, 23, 29,  2, 2000};
    tbl[16] = '{1, 1, 5, 1, 0,  0, 59, 23, 28,  2, 2001};
    tbl[17] = '{1, 1, 3, 0, 1,  0, 59, 23, 27,  2, 2001};
    tbl[18] = '{1, 1, 3, 1, 0,  0, 59, 23, 28,  2, 2001};
    tbl[19] = '{1, 1, 3, 1, 0,  0, 59, 23,  1,  2, 2001};

    m_reset();
    #12;
    chk("reset_state", dut_pk(), pk(0, 0, 0, 1, 1, 2000, 0));
    @(negedge clk) rst_n = 1'b1;

    t1 = 0; t2 = 0;
    for (int i = 1; i <= 20; i++) begin
      go(1, 0, 0, 0, 0);
      if (sec_tick === 1'b1) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
    end
    chk_i("first_tick_edge", t1, CLK_HZ + 1);
    chk_i("tick_period", t2 - t1, CLK_HZ);

    rst_n = 1'b0; m_reset();
    #2;
    chk("reset_again", dut_pk(), pk(0, 0, 0, 1, 1, 2000, 0));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      go(tbl[i].en, tbl[i].edit, tbl[i].sel, tbl[i].inc, tbl[i].dec);
      chk($sformatf("table_%0d", i), dut_pk(),
          pk(tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].d, tbl[i].mo, tbl[i].y, 0));
    end

    set_field(5, 2023); set_field(4, 1); set_field(3, 31);
    go(1, 1, 4, 1, 0);
    chk_i("clamp_month", binary_month, 2);
    chk_i("clamp_day", binary_day, 28);
    go(1, 1, 3, 0, 1);
    chk_i("day_dec", binary_day, 27);

    set_field(5, 2999); set_field(4, 12); set_field(3, 31);
    set_field(2, 23); set_field(1, 59); set_field(0, 59);
    run_to_tick(n);
    chk_i("exit_edit_latency", n, CLK_HZ + 1);
    chk("full_rollover", dut_pk(), pk(0, 0, 0, 1, 1, 2000, 1));

    leap_case("leap_2024", 2024, 2, 28, 29, 2);
    leap_case("noleap_2100", 2100, 2, 28, 1, 3);
    leap_case("leap_2000", 2000, 2, 29, 1, 3);

    for (int i = 0; i < 3 * CLK_HZ && !pend; i++) go(1, 0, 0, 0, 0);
    saved = ms;
    go(1, 1, 7, 0, 0);
    chk_i("discard_tick", binary_seconds, saved);

    set_field(2, 12); set_field(1, 34); set_field(0, 56);
    go(1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0);
    rst_n = 1'b0; m_reset();
    #2;
    chk("async_reset_mid", dut_pk(), pk(0, 0, 0, 1, 1, 2000, 0));
    @(negedge clk) rst_n = 1'b1;
    run_to_tick(n);
    chk_i("resume_latency", n, CLK_HZ + 1);
    chk("resume_count", dut_pk(), pk(1, 0, 0, 1, 1, 2000, 1));

    ed = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) ed = !ed;
      go($urandom_range(0, 9) != 0, ed, $urandom_range(0, 7),
         $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
